posit_construction: RTL and testbench

- Encoder counterpart of the posit field-extraction stage: packs sign, regime, exponent and fraction fields (plus guard/sticky bits) into a posit word.
- Rounds round-to-nearest-even with posit saturation rules.
- Sits at the back of the posit arithmetic datapath, after normalisation.
- 2-stage valid/ready pipeline, throughput 1 word/cycle.

---
 rtl/posit_construction.sv | 140 ++++++++++++++
 tb/tb_posit_construction.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/posit_construction.sv
// Posit encoder: packs sign/regime/exponent/fraction into a posit word with
// round-to-nearest-even and saturation, as a 2-stage valid/ready pipeline.
module posit_construction #(
    parameter  int posit_width  = 8,
    parameter  int es           = 1,
    localparam int frac_width   = posit_width - es - 3,
    localparam int regime_width = $clog2(posit_width) + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign,
    input  logic [regime_width-1:0] regime,
    input  logic [es-1:0]           exponent,
    input  logic [frac_width-1:0]   fraction,
    input  logic                    guard,
    input  logic                    sticky_in,
    input  logic                    zero,
    input  logic                    nar,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [posit_width-1:0]  posit
);

    localparam int buf_width  = posit_width - 1 + es + frac_width + 2;
    localparam int tail_width = es + frac_width + 1;
    localparam logic [posit_width-2:0] body_one = {{(posit_width-2){1'b0}}, 1'b1};
    localparam logic [posit_width-1:0] nar_word = {1'b1, {(posit_width-1){1'b0}}};

    logic                   s1_valid;
    logic [buf_width-1:0]   s1_buf;
    logic                   s1_sign;
    logic                   s1_sticky;
    logic                   s1_zero;
    logic                   s1_nar;
    logic                   s1_sat;

    logic                   s2_valid;
    logic [posit_width-1:0] s2_posit;
    logic                   s2_free;

    int                     k_val;
    int unsigned            reg_len;
    logic [tail_width-1:0]  tail;
    logic [buf_width-1:0]   buf_next;
    logic                   tail_lost;
    logic                   sat_next;

    logic [posit_width-2:0] body;
    logic                   rnd;
    logic                   stk;
    logic [posit_width-1:0] p;
    logic [posit_width-1:0] posit_next;

    assign s2_free   = !s2_valid || out_ready;
    assign in_ready  = en && (!s1_valid || s2_free);
    assign out_valid = s2_valid;
    assign posit     = s2_posit;
    assign tail      = {exponent, fraction, guard};

    // Stage 1: regime string followed by exponent|fraction|guard, MSB-aligned.
    always_comb begin
        k_val     = int'($signed(regime));
        reg_len   = (k_val >= 0) ? unsigned'(k_val + 2) : unsigned'(1 - k_val);
        sat_next  = (k_val >= posit_width - 2);
        buf_next  = '0;
        tail_lost = 1'b0;
        for (int unsigned j = 0; j < buf_width; j++) begin
            if (j + 1 < reg_len)
                buf_next[buf_width-1-j] = (k_val >= 0);
            else if (j + 1 == reg_len)
                buf_next[buf_width-1-j] = (k_val < 0);
            else if (j - reg_len < tail_width)
                buf_next[buf_width-1-j] = tail[tail_width-1-(j-reg_len)];
        end
        // Tail bits pushed past the buffer by long regimes still count as sticky.
        for (int unsigned t = 0; t < tail_width; t++) begin
            if (t + reg_len >= buf_width)
                tail_lost = tail_lost | tail[tail_width-1-t];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_buf    <= '0;
            s1_sign   <= 1'b0;
            s1_sticky <= 1'b0;
            s1_zero   <= 1'b0;
            s1_nar    <= 1'b0;
            s1_sat    <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_buf    <= buf_next;
                s1_sign   <= sign;
                s1_sticky <= sticky_in | tail_lost;
                s1_zero   <= zero;
                s1_nar    <= nar;
                s1_sat    <= sat_next;
            end
        end
    end

    // Stage 2: round to nearest even, saturate to maxpos/minpos, apply sign.
    always_comb begin
        body = s1_buf[buf_width-1 -: posit_width-1];
        rnd  = s1_buf[buf_width-posit_width];
        stk  = (|s1_buf[buf_width-posit_width-1:0]) | s1_sticky;
        if (rnd && (body[0] || stk) && (body != '1))
            body = body + body_one;
        if (s1_sat)
            body = '1;
        if (body == '0)
            body = body_one;
        p = {1'b0, body};
        if (s1_nar)
            posit_next = nar_word;
        else if (s1_zero)
            posit_next = '0;
        else if (s1_sign)
            posit_next = -p;
        else
            posit_next = p;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_posit <= '0;
        end else if (en && s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_posit <= posit_next;
        end
    end

endmodule

// File: tb/tb_posit_construction.sv
// Directed-vector bench for posit_construction (posit8, es=1).
module tb_posit_construction;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic       sign;
    logic [3:0] regime;
    logic [0:0] exponent;
    logic [3:0] fraction;
    logic       guard;
    logic       sticky_in;
    logic       zero;
    logic       nar;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] posit;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic       s;
        logic [3:0] k;
        logic       e;
        logic [3:0] f;
        logic       g;
        logic       st;
        logic       z;
        logic       n;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [18];

    posit_construction #(.posit_width(8), .es(1)) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .regime(regime), .exponent(exponent), .fraction(fraction),
        .guard(guard), .sticky_in(sticky_in), .zero(zero), .nar(nar),
        .out_valid(out_valid), .out_ready(out_ready), .posit(posit)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic vec_t mk(input logic s, input logic [3:0] k, input logic e,
                                input logic [3:0] f, input logic g, input logic st,
                                input logic z, input logic n, input logic [7:0] exp);
        mk = '{s: s, k: k, e: e, f: f, g: g, st: st, z: z, n: n, exp: exp};
    endfunction

    task automatic apply(input vec_t v);
        sign      = v.s;
        regime    = v.k;
        exponent  = v.e;
        fraction  = v.f;
        guard     = v.g;
        sticky_in = v.st;
        zero      = v.z;
        nar       = v.n;
    endtask

    // Call at a negedge with an empty pipe; returns at a negedge.
    task automatic run_single(input vec_t v, input string tag);
        apply(v);
        in_valid = 1'b1;
        #1;
        check({tag, "_rdy"}, 8'(in_ready), 8'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, 8'(out_valid), 8'd0);
        @(negedge clk);
        check({tag, "_vld"}, 8'(out_valid), 8'd1);
        check({tag, "_posit"}, posit, v.exp);
    endtask

    // Streams vecs[0..7]; out_ready low and en low over the given cycle windows.
    task automatic run_stream(input string tag, input int stall_at, input int stall_len,
                              input int en_at, input int en_len, input logic chk_consec);
        int tx = 0, rx = 0, occ = 0, first_out = 0, last_out = 0;
        logic was_held = 1'b0, acc, ov;
        logic [7:0] held_val = '0;
        for (int c = 0; c < 30; c++) begin
            en        = !(c >= en_at && c < en_at + en_len);
            out_ready = en && !(c >= stall_at && c < stall_at + stall_len);
            in_valid  = (tx < 8);
            if (tx < 8)
                apply(vecs[tx]);
            #1;
            check({tag, "_rdy"}, 8'(in_ready), 8'(en && (occ < 2 || out_ready)));
            if (was_held) begin
                check({tag, "_hold_vld"}, 8'(out_valid), 8'd1);
                check({tag, "_hold_posit"}, posit, held_val);
            end
            ov = out_valid && out_ready;
            if (ov) begin
                if (rx < 8)
                    check($sformatf("%s_out%0d", tag, rx), posit, vecs[rx].exp);
                else
                    check({tag, "_extra"}, 8'(out_valid), 8'd0);
                if (rx == 0)
                    first_out = c;
                last_out = c;
                rx++;
            end
            was_held = out_valid && !out_ready;
            held_val = posit;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) begin
                tx++;
                occ++;
            end
            if (ov)
                occ--;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;
        check({tag, "_count"}, 8'(rx), 8'd8);
        check({tag, "_empty"}, 8'(out_valid), 8'd0);
        if (chk_consec)
            check({tag, "_consec"}, 8'(last_out - first_out), 8'd7);
    endtask

    initial begin
        vecs[0]  = mk(1'b0, 4'd0,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40);
        vecs[1]  = mk(1'b1, 4'd0,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC0);
        vecs[2]  = mk(1'b0, 4'd1,  1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h6C);
        vecs[3]  = mk(1'b0, 4'd2,  1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 8'h73);
        vecs[4]  = mk(1'b0, 4'd2,  1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h72);
        vecs[5]  = mk(1'b0, 4'd2,  1'b0, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 8'h73);
        vecs[6]  = mk(1'b0, 4'd6,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F);
        vecs[7]  = mk(1'b1, 4'd6,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81);
        vecs[8]  = mk(1'b0, 4'hA,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
        vecs[9]  = mk(1'b0, 4'h9,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
        vecs[10] = mk(1'b0, 4'd0,  1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80);
        vecs[11] = mk(1'b1, 4'd3,  1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80);
        vecs[12] = mk(1'b0, 4'd0,  1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        vecs[13] = mk(1'b1, 4'd2,  1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        vecs[14] = mk(1'b1, 4'h9,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
        vecs[15] = mk(1'b0, 4'd7,  1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F);
        vecs[16] = mk(1'b0, 4'd0,  1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h60);
        vecs[17] = mk(1'b0, 4'd5,  1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F);

        reset_n   = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        apply(vecs[0]);
        #3;
        check("reset_vld", 8'(out_valid), 8'd0);
        check("reset_posit", posit, 8'h00);
        check("reset_rdy", 8'(in_ready), 8'd1);
        #9 reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++)
            run_single(vecs[i], $sformatf("vec%0d", i));
        @(negedge clk);

        run_stream("stream", 100, 0, 100, 0, 1'b1);
        run_stream("stall", 4, 3, 100, 0, 1'b0);
        run_stream("freeze", 100, 0, 4, 2, 1'b0);

        apply(vecs[2]);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        apply(vecs[3]);
        @(posedge clk);
        #3;
        check("rst_pre_vld", 8'(out_valid), 8'd1);
        reset_n = 1'b0;
        #1;
        check("rst_vld", 8'(out_valid), 8'd0);
        check("rst_posit", posit, 8'h00);
        in_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("rst_stale1", 8'(out_valid), 8'd0);
        check("rst_rdy", 8'(in_ready), 8'd1);
        @(negedge clk);
        check("rst_stale2", 8'(out_valid), 8'd0);
        run_single(vecs[4], "rst_new");
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
